// File: rtl/riscv_tag_pkg.sv
// riscv_tag_pkg
// Shared definitions for the DIFT tag register file slice.
//   clr_state_e   : sweep engine states (IDLE, SWEEP, DONE)
//   TAG_WIDTH_DEF : default number of tag bits per register
//   TAG_CLEAN     : value of an untainted tag (all zeros)
package riscv_tag_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } clr_state_e;

    localparam int TAG_WIDTH_DEF = 1;

    // Wide enough for the largest supported tag; truncated at the use site.
    localparam logic [7:0] TAG_CLEAN = '0;

endpackage

// File: rtl/riscv_tag_regfile_mp_if.sv
// riscv_tag_regfile_mp_if
// Bundles the read/write ports, sweep control and taint counter of the
// tag register file.
//   slave  : the register file (consumes addresses/writes, drives tags/status)
//   master : the decode stage / bench driving it
interface riscv_tag_regfile_mp_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int TAG_WIDTH  = 1,
    parameter int NUM_RD     = 3,
    parameter int NUM_WR     = 2
);
    logic                                   test_en_i;
    logic [NUM_RD-1:0][ADDR_WIDTH-1:0]      raddr_i;
    logic [NUM_RD-1:0][TAG_WIDTH-1:0]       rdata_o;
    logic [NUM_WR-1:0][ADDR_WIDTH-1:0]      waddr_i;
    logic [NUM_WR-1:0][TAG_WIDTH-1:0]       wdata_i;
    logic [NUM_WR-1:0]                      we_i;
    logic                                   clr_req_i;
    logic [TAG_WIDTH-1:0]                   clr_mask_i;
    logic                                   clr_busy_o;
    logic                                   clr_done_o;
    logic [ADDR_WIDTH:0]                    taint_cnt_o;

    modport slave (
        input  test_en_i, raddr_i, waddr_i, wdata_i, we_i, clr_req_i, clr_mask_i,
        output rdata_o, clr_busy_o, clr_done_o, taint_cnt_o
    );

    modport master (
        output test_en_i, raddr_i, waddr_i, wdata_i, we_i, clr_req_i, clr_mask_i,
        input  rdata_o, clr_busy_o, clr_done_o, taint_cnt_o
    );
endinterface

// File: rtl/riscv_tag_wr_arb.sv
// riscv_tag_wr_arb
// Priority write decoder: for every register index, reports whether any
// enabled write port targets it and which data wins. Higher port index wins.
//   i_waddr : per-port write address
//   i_wdata : per-port write tag
//   i_we    : per-port write enable
//   o_en    : per-index write enable
//   o_data  : per-index selected write tag
module riscv_tag_wr_arb #(
    parameter int ADDR_WIDTH = 5,
    parameter int TAG_WIDTH  = 1,
    parameter int NUM_WR     = 2
) (
    input  logic [NUM_WR-1:0][ADDR_WIDTH-1:0]        i_waddr,
    input  logic [NUM_WR-1:0][TAG_WIDTH-1:0]         i_wdata,
    input  logic [NUM_WR-1:0]                        i_we,
    output logic [(2**ADDR_WIDTH)-1:0]               o_en,
    output logic [(2**ADDR_WIDTH)-1:0][TAG_WIDTH-1:0] o_data
);
    localparam int NUM_WORDS = 2**ADDR_WIDTH;

    // Ports are scanned in ascending order so a later (higher) port overrides.
    always_comb begin
        o_en   = '0;
        o_data = '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            for (int p = 0; p < NUM_WR; p++) begin
                if (i_we[p] && (i_waddr[p] == ADDR_WIDTH'(i))) begin
                    o_en[i]   = 1'b1;
                    o_data[i] = i_wdata[p];
                end
            end
        end
    end
endmodule

// File: rtl/riscv_tag_regfile_mp.sv
// riscv_tag_regfile_mp
// DIFT tag register file: one tag per architectural register, NUM_RD
// combinational read ports, NUM_WR prioritised write ports, x0 hardwired
// clean, a background sweep that clears selected tag bits across the file,
// and a registered count of tainted registers.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : riscv_tag_regfile_mp_if slave (reads, writes, sweep, taint)
// Optional build macro TAG_RF_FORWARD_EN: same-cycle port writes are
// forwarded to matching reads (sweep effects never are).
module riscv_tag_regfile_mp
    import riscv_tag_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int TAG_WIDTH  = TAG_WIDTH_DEF,
    parameter int NUM_RD     = 3,
    parameter int NUM_WR     = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    riscv_tag_regfile_mp_if.slave  bus
);
    localparam int NUM_WORDS = 2**ADDR_WIDTH;
    localparam logic [TAG_WIDTH-1:0]  W_CLEAN  = TAG_WIDTH'(TAG_CLEAN);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_WORDS - 1);

    logic [TAG_WIDTH-1:0]                 r_tags [1:NUM_WORDS-1];
    clr_state_e                           r_state;
    logic [ADDR_WIDTH-1:0]                r_idx;
    logic [TAG_WIDTH-1:0]                 r_mask;
    logic [ADDR_WIDTH:0]                  r_taint;

    logic [NUM_WORDS-1:0]                 w_wrEn;
    logic [NUM_WORDS-1:0][TAG_WIDTH-1:0]  w_wrData;
    logic [NUM_WORDS-1:0][TAG_WIDTH-1:0]  w_view;
    logic [NUM_RD-1:0][TAG_WIDTH-1:0]     w_rdata;
    logic [ADDR_WIDTH:0]                  w_taintNext;
    logic                                 w_unused;

    // Scan enable has no functional effect; index 0 of the decoder is never stored.
    assign w_unused = ^{bus.test_en_i, w_wrEn[0], w_wrData[0]};

    riscv_tag_wr_arb #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .TAG_WIDTH  (TAG_WIDTH),
        .NUM_WR     (NUM_WR)
    ) u_wr_arb (
        .i_waddr (bus.waddr_i),
        .i_wdata (bus.wdata_i),
        .i_we    (bus.we_i),
        .o_en    (w_wrEn),
        .o_data  (w_wrData)
    );

    // Storage: a port write beats the sweep on the same index and is kept unmasked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NUM_WORDS; i++) r_tags[i] <= W_CLEAN;
        end else begin
            for (int i = 1; i < NUM_WORDS; i++) begin
                if (w_wrEn[i])
                    r_tags[i] <= w_wrData[i];
                else if ((r_state == SWEEP) && (r_idx == ADDR_WIDTH'(i)))
                    r_tags[i] <= r_tags[i] & ~r_mask;
            end
        end
    end

    // Sweep engine: requests are only looked at in IDLE, so they never queue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_idx   <= ADDR_WIDTH'(1);
            r_mask  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.clr_req_i) begin
                        r_state <= SWEEP;
                        r_mask  <= bus.clr_mask_i;
                        r_idx   <= ADDR_WIDTH'(1);
                    end
                end
                SWEEP: begin
                    if (r_idx == LAST_IDX) begin
                        r_state <= DONE;
                        r_idx   <= ADDR_WIDTH'(1);
                    end else begin
                        r_idx <= r_idx + ADDR_WIDTH'(1);
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Population count of tainted registers over the currently stored state.
    always_comb begin
        w_taintNext = '0;
        for (int i = 1; i < NUM_WORDS; i++)
            w_taintNext = w_taintNext + (ADDR_WIDTH+1)'(r_tags[i] != W_CLEAN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_taint <= '0;
        else        r_taint <= w_taintNext;
    end

    // Flat view of the file with x0 pinned clean, indexed directly by read addresses.
    always_comb begin
        w_view[0] = W_CLEAN;
        for (int i = 1; i < NUM_WORDS; i++) w_view[i] = r_tags[i];
    end

    always_comb begin
        w_rdata = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            w_rdata[r] = w_view[bus.raddr_i[r]];
`ifdef TAG_RF_FORWARD_EN
            if ((bus.raddr_i[r] != '0) && w_wrEn[bus.raddr_i[r]])
                w_rdata[r] = w_wrData[bus.raddr_i[r]];
`endif
        end
    end

    assign bus.rdata_o     = w_rdata;
    assign bus.clr_busy_o  = (r_state != IDLE);
    assign bus.clr_done_o  = (r_state == DONE);
    assign bus.taint_cnt_o = r_taint;
endmodule

// File: tb/tb_riscv_tag_regfile_mp.sv
// tb_riscv_tag_regfile_mp
// Directed bench for riscv_tag_regfile_mp with 4-bit tags, 32 registers,
// 3 read ports and 2 write ports. Honours TAG_RF_FORWARD_EN for the
// same-cycle read expectations.
module tb_riscv_tag_regfile_mp;
    logic clk;
    logic rst_n;
    int   testsRun;
    int   testsFailed;

    riscv_tag_regfile_mp_if #(
        .ADDR_WIDTH (5), .TAG_WIDTH (4), .NUM_RD (3), .NUM_WR (2)
    ) bus ();

    riscv_tag_regfile_mp #(
        .ADDR_WIDTH (5), .TAG_WIDTH (4), .NUM_RD (3), .NUM_WR (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Read a register on port 0 while idle and compare at the falling edge
    task automatic checkTag(input string tag, input logic [4:0] addr, input logic [3:0] expected);
        bus.raddr_i[0] = addr;
        @(negedge clk);
        checkOutput(tag, 32'(bus.rdata_o[0]), 32'(expected));
    endtask

    task automatic applyStimulus(input int port, input logic [4:0] addr, input logic [3:0] data);
        bus.we_i[port]    = 1'b1;
        bus.waddr_i[port] = addr;
        bus.wdata_i[port] = data;
    endtask

    task automatic clearWrites();
        bus.we_i    = '0;
        bus.waddr_i = '0;
        bus.wdata_i = '0;
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst_n          = 1'b0;
        bus.test_en_i  = 1'b0;
        bus.raddr_i    = '0;
        bus.clr_req_i  = 1'b0;
        bus.clr_mask_i = '0;
        clearWrites();

        // Reset state
        #12;
        checkOutput("rst_busy", 32'(bus.clr_busy_o), 32'd0);
        checkOutput("rst_done", 32'(bus.clr_done_o), 32'd0);
        checkOutput("rst_taint", 32'(bus.taint_cnt_o), 32'd0);
        rst_n = 1'b1;
        cyc();
        checkOutput("rst_x5", 32'(bus.rdata_o[0]), 32'd0);

        // Two ports hit x5 in the same cycle: port 1 wins
        bus.raddr_i[0] = 5'd5;
        applyStimulus(0, 5'd5, 4'hA);
        applyStimulus(1, 5'd5, 4'h3);
        #1;
`ifdef TAG_RF_FORWARD_EN
        checkOutput("prio_fwd_x5", 32'(bus.rdata_o[0]), 32'h3);
`else
        checkOutput("prio_same_cycle_x5", 32'(bus.rdata_o[0]), 32'h0);
`endif
        cyc();
        clearWrites();
        #1;
        checkOutput("prio_x5", 32'(bus.rdata_o[0]), 32'h3);
        checkOutput("prio_taint_lag", 32'(bus.taint_cnt_o), 32'd0);
        cyc();
        checkOutput("prio_taint", 32'(bus.taint_cnt_o), 32'd1);

        // Writes to x0 are dropped
        bus.raddr_i[1] = 5'd0;
        applyStimulus(0, 5'd0, 4'hF);
        cyc();
        clearWrites();
        checkOutput("x0_read", 32'(bus.rdata_o[1]), 32'd0);
        cyc();
        checkOutput("x0_taint", 32'(bus.taint_cnt_o), 32'd1);

        // Same-cycle read of a write to x7
        bus.raddr_i[2] = 5'd7;
        applyStimulus(1, 5'd7, 4'h6);
        #1;
`ifdef TAG_RF_FORWARD_EN
        checkOutput("fwd_x7_same", 32'(bus.rdata_o[2]), 32'h6);
`else
        checkOutput("nofwd_x7_same", 32'(bus.rdata_o[2]), 32'h0);
`endif
        cyc();
        clearWrites();
        checkOutput("x7_next", 32'(bus.rdata_o[2]), 32'h6);
        cyc();
        checkOutput("x7_taint", 32'(bus.taint_cnt_o), 32'd2);

        // Preload x1..x31 with 4'hF
        for (int i = 1; i < 32; i++) begin
            applyStimulus(0, 5'(i), 4'hF);
            cyc();
        end
        clearWrites();
        checkOutput("preload_taint_lag", 32'(bus.taint_cnt_o), 32'd30);
        cyc();
        checkOutput("preload_taint", 32'(bus.taint_cnt_o), 32'd31);

        // Full sweep with mask 4'h5; mask input changes after capture
        bus.clr_req_i  = 1'b1;
        bus.clr_mask_i = 4'h5;
        cyc();
        bus.clr_req_i  = 1'b0;
        bus.clr_mask_i = 4'h0;
        checkOutput("sw1_busy_start", 32'(bus.clr_busy_o), 32'd1);
        checkOutput("sw1_done_start", 32'(bus.clr_done_o), 32'd0);
        repeat (30) cyc();
        checkOutput("sw1_done_c31", 32'(bus.clr_done_o), 32'd0);
        cyc();
        checkOutput("sw1_done_c32", 32'(bus.clr_done_o), 32'd1);
        checkOutput("sw1_busy_c32", 32'(bus.clr_busy_o), 32'd1);
        cyc();
        checkOutput("sw1_done_c33", 32'(bus.clr_done_o), 32'd0);
        checkOutput("sw1_busy_c33", 32'(bus.clr_busy_o), 32'd0);
        for (int i = 1; i < 32; i++) checkTag($sformatf("sw1_x%0d", i), 5'(i), 4'hA);
        checkTag("sw1_x0", 5'd0, 4'h0);
        cyc();
        checkOutput("sw1_taint", 32'(bus.taint_cnt_o), 32'd31);

        // Sweep with writes racing it, plus an ignored mid-sweep request
        bus.clr_req_i  = 1'b1;
        bus.clr_mask_i = 4'h5;
        cyc();
        bus.clr_req_i  = 1'b0;
        bus.clr_mask_i = 4'h0;
        cyc();
        bus.clr_req_i  = 1'b1;
        bus.clr_mask_i = 4'hF;
        cyc();
        bus.clr_req_i  = 1'b0;
        bus.clr_mask_i = 4'h0;
        repeat (17) cyc();
        applyStimulus(0, 5'd20, 4'hF);
        cyc();
        applyStimulus(0, 5'd3, 4'hF);
        cyc();
        clearWrites();
        repeat (10) cyc();
        checkOutput("sw2_done_c32", 32'(bus.clr_done_o), 32'd1);
        cyc();
        checkOutput("sw2_busy_end", 32'(bus.clr_busy_o), 32'd0);
        checkTag("sw2_x20", 5'd20, 4'hF);
        checkTag("sw2_x3", 5'd3, 4'hF);
        checkTag("sw2_x21", 5'd21, 4'hA);
        checkTag("sw2_x2", 5'd2, 4'hA);
        checkTag("sw2_x31", 5'd31, 4'hA);

        // Reset at idx=10 aborts the sweep
        bus.clr_req_i  = 1'b1;
        bus.clr_mask_i = 4'h5;
        cyc();
        bus.clr_req_i  = 1'b0;
        repeat (9) cyc();
        checkOutput("abort_busy_pre", 32'(bus.clr_busy_o), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", 32'(bus.clr_busy_o), 32'd0);
        checkOutput("abort_done", 32'(bus.clr_done_o), 32'd0);
        checkOutput("abort_taint", 32'(bus.taint_cnt_o), 32'd0);
        checkTag("abort_x20", 5'd20, 4'h0);
        checkTag("abort_x3", 5'd3, 4'h0);
        repeat (3) cyc();
        checkOutput("abort_done_hold", 32'(bus.clr_done_o), 32'd0);
        rst_n = 1'b1;
        cyc();
        checkOutput("post_rst_busy", 32'(bus.clr_busy_o), 32'd0);
        checkOutput("post_rst_done", 32'(bus.clr_done_o), 32'd0);

        // New request accepted after reset; mask 4'h4 turns 4'hC into 4'h8
        applyStimulus(1, 5'd9, 4'hC);
        cyc();
        clearWrites();
        bus.clr_req_i  = 1'b1;
        bus.clr_mask_i = 4'h4;
        cyc();
        bus.clr_req_i  = 1'b0;
        bus.clr_mask_i = 4'h0;
        checkOutput("sw3_busy", 32'(bus.clr_busy_o), 32'd1);
        repeat (31) cyc();
        checkOutput("sw3_done", 32'(bus.clr_done_o), 32'd1);
        cyc();
        checkOutput("sw3_idle", 32'(bus.clr_busy_o), 32'd0);
        checkTag("sw3_x9", 5'd9, 4'h8);
        checkTag("sw3_x10", 5'd10, 4'h0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
